// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM between two requesters (e.g. I-cache and D-cache).
// Grants one port at a time with round-robin tie-breaking and drives the RAM through a
// start/busy handshake (start_ram strobe, response_ram busy level).
//
// Optional feature: define ARB_TIMEOUT_EN to build a 16-bit WAIT watchdog that aborts a
// transaction after TIMEOUT busy cycles and flags err0/err1. Without it, err0/err1 are 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0/1, mode0/1               request level (held until done), 0 = read, 1 = write
//   address0/1, data0/1           transaction address and write data
//   busy0/1                       port owns the RAM (ISSUE or WAIT)
//   done0/1                       one-cycle completion pulse
//   out0/1                        registered read data, held until the next read completion
//   err0/1                        timeout flag, valid with done
//   start_ram, mode_ram           RAM start strobe and mode
//   address_ram, data_ram         RAM address and write data, stable ISSUE..DONE
//   out_ram, response_ram         RAM read data and busy level
module ram_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              mode0,
  input  logic              mode1,
  input  logic [ADDR_W-1:0] address0,
  input  logic [ADDR_W-1:0] address1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              busy0,
  output logic              busy1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              err0,
  output logic              err1,
  output logic              start_ram,
  output logic              mode_ram,
  output logic [ADDR_W-1:0] address_ram,
  output logic [DATA_W-1:0] data_ram,
  input  logic [DATA_W-1:0] out_ram,
  input  logic              response_ram
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_q;   // 0 = port 0 owns the RAM, 1 = port 1
  logic              last_q;    // port granted most recently
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] out0_q, out1_q;
  logic              grant;
  logic              grant_port;
  logic              timeout;
  logic              capture;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_port = 1'b0;
    case (state_q)
      StIdle: begin
        // Never start while the RAM is still busy (e.g. an access abandoned by reset).
        if (!response_ram && (req0 || req1)) begin
          grant      = 1'b1;
          grant_port = (req0 && req1) ? ~last_q : req1;
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (!response_ram || timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read data is valid on the first WAIT cycle the RAM reports idle.
  assign capture = (state_q == StWait) && !response_ram && !mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_port;
        last_q  <= grant_port;
        mode_q  <= grant_port ? mode1 : mode0;
        addr_q  <= grant_port ? address1 : address0;
        data_q  <= grant_port ? data1 : data0;
      end
      if (capture) begin
        if (owner_q) begin
          out1_q <= out_ram;
        end else begin
          out0_q <= out_ram;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  logic [15:0] cnt_q;
  logic        err0_q, err1_q;

  // Fires on the TIMEOUT-th WAIT cycle that still sees the RAM busy.
  assign timeout = (state_q == StWait) && response_ram && ((cnt_q + 16'd1) == TimeoutCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (grant && !grant_port) begin
        err0_q <= 1'b0;
      end
      if (grant && grant_port) begin
        err1_q <= 1'b0;
      end
      if (timeout) begin
        if (owner_q) begin
          err1_q <= 1'b1;
        end else begin
          err0_q <= 1'b1;
        end
      end
    end
  end

  assign err0 = err0_q;
  assign err1 = err1_q;
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign err0           = 1'b0;
  assign err1           = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  assign start_ram   = (state_q == StIssue);
  assign busy0       = ((state_q == StIssue) || (state_q == StWait)) && !owner_q;
  assign busy1       = ((state_q == StIssue) || (state_q == StWait)) && owner_q;
  assign done0       = (state_q == StDone) && !owner_q;
  assign done1       = (state_q == StDone) && owner_q;
  assign mode_ram    = mode_q;
  assign address_ram = addr_q;
  assign data_ram    = data_q;
  assign out0        = out0_q;
  assign out1        = out1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
  logic [31:0] address0 = '0, address1 = '0, data0 = '0, data1 = '0;
  logic        busy0, busy1, done0, done1, err0, err1, start_ram, mode_ram;
  logic [31:0] out0, out1, address_ram, data_ram;
  logic [31:0] out_ram = '0;
  logic        response_ram = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .DATA_W (32),
    .ADDR_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .mode0       (mode0),
    .mode1       (mode1),
    .address0    (address0),
    .address1    (address1),
    .data0       (data0),
    .data1       (data1),
    .busy0       (busy0),
    .busy1       (busy1),
    .done0       (done0),
    .done1       (done1),
    .out0        (out0),
    .out1        (out1),
    .err0        (err0),
    .err1        (err1),
    .start_ram   (start_ram),
    .mode_ram    (mode_ram),
    .address_ram (address_ram),
    .data_ram    (data_ram),
    .out_ram     (out_ram),
    .response_ram(response_ram)
  );

  // Contents of a never-written RAM word; 0x10 holds 0xDEADBEEF.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hDEADBEEF ^ ((a ^ 32'h10) << 8);
  endfunction

  // RAM environment: busy ram_lat cycles after a start, stuck high while ram_stuck.
  logic [31:0] ram_mem [256];
  bit          ram_vld [256];
  logic [31:0] ram_rd = '0;
  int          ram_cnt = 0;
  int          ram_lat = 3;
  bit          ram_stuck = 1'b0;

  always @(posedge clk) begin
    if (ram_cnt != 0) begin
      if (!ram_stuck) begin
        ram_cnt <= ram_cnt - 1;
        if (ram_cnt == 1) begin
          response_ram <= 1'b0;
          out_ram      <= ram_rd;
        end
      end
    end else if (start_ram) begin
      response_ram <= 1'b1;
      ram_cnt      <= ram_lat;
      if (mode_ram) begin
        ram_mem[address_ram[9:2]] <= data_ram;
        ram_vld[address_ram[9:2]] <= 1'b1;
      end else begin
        ram_rd <= ram_vld[address_ram[9:2]] ? ram_mem[address_ram[9:2]] : dflt(address_ram);
      end
    end
  end

  // Reference model state: memory image, per-port read data, last granted port.
  logic [31:0] ref_mem [256];
  bit          ref_vld [256];
  logic [31:0] ref_out [2];
  int          ref_last = 1;

  logic        cur_mode [2];
  logic [31:0] cur_addr [2];
  logic [31:0] cur_data [2];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic r);
    if (p == 0) begin
      req0 = r; mode0 = cur_mode[0]; address0 = cur_addr[0]; data0 = cur_data[0];
    end else begin
      req1 = r; mode1 = cur_mode[1]; address1 = cur_addr[1]; data1 = cur_data[1];
    end
  endtask

  task automatic randomize_port(input int p);
    cur_mode[p] = 1'($urandom_range(0, 1));
    cur_addr[p] = 32'h100 + 32'($urandom_range(0, 7)) * 4;
    cur_data[p] = $urandom;
  endtask

  int          st_at, dn_at;
  logic        snap_mode, snap_b0, snap_b1;
  logic [31:0] snap_addr, snap_data;

  task automatic wait_txn();
    st_at = -1;
    dn_at = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (start_ram === 1'b1 && st_at < 0) begin
        st_at = c; snap_mode = mode_ram; snap_addr = address_ram; snap_data = data_ram;
        snap_b0 = busy0; snap_b1 = busy1;
      end
      if (done0 === 1'b1 || done1 === 1'b1) begin
        dn_at = c;
        break;
      end
    end
  endtask

  // Serves n0 transactions from port 0 and n1 from port 1; ports keep requesting while
  // they have work left. Called at a negedge in IDLE with the RAM idle.
  task automatic run_step(input int n0, input int n1);
    int rem [2];
    int w;
    int ofs;
    rem[0] = n0;
    rem[1] = n1;
    drive(0, rem[0] > 0);
    drive(1, rem[1] > 0);
    ofs = 0;
    while (rem[0] + rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) w = (ref_last == 1) ? 0 : 1;
      else w = (rem[0] > 0) ? 0 : 1;
      wait_txn();
      chk("start_cycle", 64'(st_at), 64'(1 + ofs));
      chk("done_cycle", 64'(dn_at), 64'(ram_lat + 3 + ofs));
      if (dn_at < 0) begin
        req0 = 1'b0; req1 = 1'b0;
        return;
      end
      chk("mode_ram", 64'(snap_mode), 64'(cur_mode[w]));
      chk("address_ram", 64'(snap_addr), 64'(cur_addr[w]));
      chk("data_ram", 64'(snap_data), 64'(cur_data[w]));
      chk("busy_owner", 64'(w ? snap_b1 : snap_b0), 64'd1);
      chk("busy_other", 64'(w ? snap_b0 : snap_b1), 64'd0);
      chk("done_owner", 64'(w ? done1 : done0), 64'd1);
      chk("done_other", 64'(w ? done0 : done1), 64'd0);
      chk("address_hold", 64'(address_ram), 64'(cur_addr[w]));
      if (cur_mode[w]) begin
        ref_mem[cur_addr[w][9:2]] = cur_data[w];
        ref_vld[cur_addr[w][9:2]] = 1'b1;
      end else begin
        ref_out[w] = ref_vld[cur_addr[w][9:2]] ? ref_mem[cur_addr[w][9:2]] : dflt(cur_addr[w]);
      end
      chk("out0", 64'(out0), 64'(ref_out[0]));
      chk("out1", 64'(out1), 64'(ref_out[1]));
      chk("err_owner", 64'(w ? err1 : err0), 64'd0);
      ref_last = w;
      rem[w]--;
      if (rem[w] > 0) begin
        randomize_port(w);
        drive(w, 1'b1);
      end else begin
        drive(w, 1'b0);
      end
      ofs = 1;
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'({busy0, busy1}), 64'd0);
    chk({tag, "_done"}, 64'({done0, done1}), 64'd0);
    chk({tag, "_err"}, 64'({err0, err1}), 64'd0);
    chk({tag, "_start_mode"}, 64'({start_ram, mode_ram}), 64'd0);
    chk({tag, "_address_ram"}, 64'(address_ram), 64'd0);
    chk({tag, "_data_ram"}, 64'(data_ram), 64'd0);
    chk({tag, "_out0"}, 64'(out0), 64'd0);
    chk({tag, "_out1"}, 64'(out1), 64'd0);
  endtask

  initial begin
    int viol;
    int n0, n1;
    ref_out[0] = '0;
    ref_out[1] = '0;
    for (int p = 0; p < 2; p++) begin
      cur_mode[p] = 1'b0; cur_addr[p] = '0; cur_data[p] = '0;
    end

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single read on port 0.
    ram_lat = 3;
    cur_mode[0] = 1'b0; cur_addr[0] = 32'h10; cur_data[0] = 32'h0;
    run_step(1, 0);
    chk("single_read_out0", 64'(out0), 64'hDEADBEEF);

    // Two ties: port 0 first both times.
    cur_mode[0] = 1'b0; cur_addr[0] = 32'h20;
    cur_mode[1] = 1'b0; cur_addr[1] = 32'h30;
    run_step(1, 1);
    run_step(1, 1);

    // Write on port 1.
    cur_mode[1] = 1'b1; cur_data[1] = 32'h12345678; cur_addr[1] = 32'h40;
    run_step(0, 1);

    // Port 0 keeps requesting while port 1 competes.
    randomize_port(0);
    randomize_port(1);
    run_step(2, 2);

    // Randomized traffic.
    for (int s = 0; s < 20; s++) begin
      ram_lat = $urandom_range(1, 5);
      randomize_port(0);
      randomize_port(1);
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      run_step(n0, n1);
    end

    // Reset during WAIT with the RAM still busy.
    ram_lat = 8;
    cur_mode[0] = 1'b0; cur_addr[0] = 32'h10; cur_data[0] = '0;
    drive(0, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_before_reset", 64'(busy0), 64'd1);
    req0 = 1'b0;
    cur_mode[1] = 1'b0; cur_addr[1] = 32'h20; cur_data[1] = '0;
    drive(1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    ref_last = 1;
    ref_out[0] = '0;
    ref_out[1] = '0;
    ram_lat = 2;
    viol = 0;
    for (int c = 0; c < 50 && response_ram === 1'b1; c++) begin
      if (start_ram !== 1'b0) viol++;
      @(negedge clk);
    end
    chk("no_start_while_busy", 64'(viol), 64'd0);
    run_step(0, 1);

`ifdef ARB_TIMEOUT_EN
    // RAM stuck busy: abort after the watchdog expires.
    ram_stuck = 1'b1;
    ram_lat = 2;
    cur_mode[0] = 1'b0; cur_addr[0] = 32'h30; cur_data[0] = '0;
    drive(0, 1'b1);
    wait_txn();
    chk("to_start_cycle", 64'(st_at), 64'd1);
    chk("to_done_cycle", 64'(dn_at), 64'd10);
    chk("to_done0", 64'(done0), 64'd1);
    chk("to_err0", 64'(err0), 64'd1);
    chk("to_out0", 64'(out0), 64'(ref_out[0]));
    req0 = 1'b0;
    ram_stuck = 1'b0;
    ref_last = 0;
    for (int c = 0; c < 50 && response_ram === 1'b1; c++) @(negedge clk);
    run_step(1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single `ram` instance between two cache front-ends, such as an instruction cache and a data cache. It accepts read and write transactions from two ports, grants the RAM to one port at a time using round-robin priority, and drives the RAM through a start/busy handshake. It returns read data and a completion pulse to the owning port. It sits between the caches and `ram`, replacing each cache's private RAM instance.

## Interface
Parameters:
- `DATA_W`, 32, data width of all data ports.
- `ADDR_W`, 32, address width of all address ports.
- `TIMEOUT`, 64, maximum WAIT cycles before abort. Only used when `ARB_TIMEOUT_EN` is defined. Legal range 1..65535.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request, level; held until `done_n`.
- `mode0`, `mode1`  in  1  0 = read, 1 = write.
- `address0`, `address1`  in  ADDR_W  transaction address.
- `data0`, `data1`  in  DATA_W  write data; ignored on read.
- `busy0`, `busy1`  out  1  port owns the RAM (ISSUE or WAIT).
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `out0`, `out1`  out  DATA_W  read data, registered; holds until the next read completion on that port.
- `err0`, `err1`  out  1  timeout flag, valid with `done_n`.
- `start_ram`  out  1  one-cycle RAM start strobe.
- `mode_ram`  out  1  RAM mode.
- `address_ram`  out  ADDR_W  RAM address.
- `data_ram`  out  DATA_W  RAM write data.
- `out_ram`  in  DATA_W  RAM read data; valid when `response_ram` falls.
- `response_ram`  in  1  1 = RAM busy, 0 = idle/finished.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples `req0`/`req1` only when `response_ram == 0`.
  - If exactly one request is high, that port is granted.
  - If both are high, the port not granted last time wins. The `last` register resets to 1, so port 0 wins the first tie.
  - On grant: latch the granted port's `address`, `data`, and `mode` into the RAM-side registers, record the owner and `last`, then go to ISSUE.
- ISSUE: `start_ram = 1` for exactly this cycle; go to WAIT.
- WAIT:
  - While `response_ram == 1`, stay.
  - On the first cycle `response_ram == 0`:
    - For a read, capture `out_ram` into the owner's `out_n`.
    - For a write, leave `out_n` unchanged.
  - Then go to DONE.
- DONE:
  - `done_n = 1` for the owner only; go to IDLE.
  - Requests are not sampled in DONE.
  - The requester must deassert `req_n` on the edge where it sees `done_n`. A request still high in the following IDLE is treated as a new transaction.
- `address_ram`, `data_ram`, and `mode_ram` stay stable from ISSUE through DONE. The inputs of the non-owning port are ignored during that window.
- `busy_n` is asserted in ISSUE and WAIT for the owner.
- Reset mid-transaction:
  - State goes to IDLE and all outputs are cleared.
  - The in-flight RAM access is abandoned. The IDLE gate on `response_ram == 0` prevents overlapping a still-busy RAM.

## Timing
- Reset values:
  - `busy*`, `done*`, `err*`, `start_ram`, `mode_ram`: 0.
  - `out*`, `address_ram`, `data_ram`: 0.
  - State: IDLE; `last`: 1.
- RAM contract: `response_ram` rises the cycle after `start_ram` and falls when `out_ram` is valid.
- For a RAM busy for N cycles, with the request sampled in IDLE at cycle 0:
  - ISSUE at cycle 1.
  - WAIT at cycles 2..N+2.
  - `done_n` at cycle N+3.
  - Next IDLE sample at cycle N+4.
- Minimum request-to-request spacing on one port is N+4 cycles.
- Grant decision and `busy_n` rise take one cycle after the request is sampled.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A 16-bit WAIT counter clears on ISSUE and increments each WAIT cycle.
  - If it reaches `TIMEOUT` while `response_ram == 1`, the FSM goes to DONE with `err_n = 1`.
  - `out_n` is unchanged on timeout.
  - `err_n` clears on the next grant to that port.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built; WAIT waits indefinitely.
  - `err0`/`err1` are tied 0.

## Test plan
- Single read on port 0: `address0 = 0x10`, RAM busy 3 cycles, returns `0xDEADBEEF`. Expect `start_ram` at cycle 1, `done0` at cycle 6, `out0 = 0xDEADBEEF`, and `busy1`, `done1`, `out1` all 0 throughout.
- Simultaneous `req0` and `req1` after reset (reads of 0x20 and 0x30): port 0 is served first, then port 1. Repeat the tie: port 0 is served first again, because `last = 1` after port 1's grant.
- Write on port 1: `mode1 = 1`, `data1 = 0x12345678`, `address1 = 0x40`. Expect `mode_ram = 1`, `data_ram = 0x12345678`, `done1` pulses, and `out1` unchanged.
- Port 0 holds `req0` continuously while port 1 requests. Expect grants to alternate 0, 1, 0, 1 with no starvation.
- `rst` asserted during WAIT, while `response_ram` is still 1. Expect all outputs 0 next cycle, no `start_ram` until `response_ram == 0`, then a pending request is served normally.
- With `ARB_TIMEOUT_EN` and `TIMEOUT = 8`, `response_ram` is stuck at 1. Expect `done0` with `err0 = 1` exactly 8 WAIT cycles after ISSUE, and `out0` unchanged.
